// File: rtl/flash_read_arbiter.sv
// Arbitrates 6809 CPU and DMA byte reads onto a single SPI flash read engine,
// with a one-entry read cache in front of the CPU path and a per-read timeout.
module flash_read_arbiter #(
    parameter int TIMEOUT = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    output logic [7:0]  cpu_data,
    output logic        cpu_ready,
    input  logic        dma_req,
    input  logic [23:0] dma_addr,
    output logic [7:0]  dma_data,
    output logic        dma_ack,
    output logic        eng_start,
    output logic [23:0] eng_addr,
    input  logic        eng_done,
    input  logic [7:0]  eng_data,
    output logic        timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic       OWN_CPU  = 1'b0;
    localparam logic       OWN_DMA  = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        eng_start_q, eng_start_d;
    logic [23:0] eng_addr_q, eng_addr_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic [7:0]  cpu_data_q, cpu_data_d;
    logic        dma_ack_q, dma_ack_d;
    logic [7:0]  dma_data_q, dma_data_d;
    logic        timeout_err_q, timeout_err_d;
    logic        cache_vld_q, cache_vld_d;
    logic [23:0] cache_tag_q, cache_tag_d;
    logic [7:0]  cache_data_q, cache_data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  rd_data_q, rd_data_d;

    logic [23:0] cpu_eff;
    logic        cpu_pend, dma_pend, cpu_hit, cpu_miss, grant_dma;

    // The upper CPU address bits are decoded before the request reaches here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[15:12];

    assign cpu_eff  = {12'h000, cpu_addr[11:0]};
    assign cpu_pend = cpu_req & ~cpu_ready_q;
    assign dma_pend = dma_req & ~dma_ack_q;
    assign cpu_hit  = cpu_pend & cache_vld_q & (cache_tag_q == cpu_eff);
    assign cpu_miss = cpu_pend & ~cpu_hit;

    always_comb begin
        state_d       = state_q;
        eng_start_d   = 1'b0;
        eng_addr_d    = eng_addr_q;
        cpu_ready_d   = cpu_ready_q & cpu_req;
        cpu_data_d    = cpu_data_q;
        dma_ack_d     = 1'b0;
        dma_data_d    = dma_data_q;
        timeout_err_d = timeout_err_q;
        cache_vld_d   = cache_vld_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
        cnt_d         = cnt_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        rd_data_d     = rd_data_q;
        grant_dma     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_hit) begin
                    cpu_data_d  = cache_data_q;
                    cpu_ready_d = 1'b1;
                end else if (cpu_miss || dma_pend) begin
                    // On a tie the requester that did not win last time goes first.
                    grant_dma    = dma_pend && (!cpu_miss || last_grant_q == OWN_CPU);
                    eng_addr_d   = grant_dma ? dma_addr : cpu_eff;
                    owner_d      = grant_dma ? OWN_DMA : OWN_CPU;
                    last_grant_d = grant_dma ? OWN_DMA : OWN_CPU;
                    eng_start_d  = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    rd_data_d    = eng_data;
                    cache_vld_d  = 1'b1;
                    cache_tag_d  = eng_addr_q;
                    cache_data_d = eng_data;
                    state_d      = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rd_data_d     = 8'hFF;
                    timeout_err_d = 1'b1;
                    cache_vld_d   = 1'b0;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (owner_q == OWN_CPU) begin
                    cpu_data_d  = rd_data_q;
                    cpu_ready_d = 1'b1;
                end else begin
                    dma_data_d = rd_data_q;
                    dma_ack_d  = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            eng_start_q   <= 1'b0;
            eng_addr_q    <= 24'h000000;
            cpu_ready_q   <= 1'b0;
            cpu_data_q    <= 8'h00;
            dma_ack_q     <= 1'b0;
            dma_data_q    <= 8'h00;
            timeout_err_q <= 1'b0;
            cache_vld_q   <= 1'b0;
            cnt_q         <= 8'd0;
            owner_q       <= OWN_CPU;
            last_grant_q  <= OWN_DMA;
        end else begin
            state_q       <= state_d;
            eng_start_q   <= eng_start_d;
            eng_addr_q    <= eng_addr_d;
            cpu_ready_q   <= cpu_ready_d;
            cpu_data_q    <= cpu_data_d;
            dma_ack_q     <= dma_ack_d;
            dma_data_q    <= dma_data_d;
            timeout_err_q <= timeout_err_d;
            cache_vld_q   <= cache_vld_d;
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
        end
        cache_tag_q  <= cache_tag_d;
        cache_data_q <= cache_data_d;
        rd_data_q    <= rd_data_d;
    end

    assign eng_start   = eng_start_q;
    assign eng_addr    = eng_addr_q;
    assign cpu_ready   = cpu_ready_q;
    assign cpu_data    = cpu_data_q;
    assign dma_ack     = dma_ack_q;
    assign dma_data    = dma_data_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: miss/hit paths, arbitration order,
// timeout abort and mid-read reset, checked with immediate assertions.
module tb_flash_read_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_ready;
    logic        dma_req;
    logic [23:0] dma_addr;
    logic [7:0]  dma_data;
    logic        dma_ack;
    logic        eng_start;
    logic [23:0] eng_addr;
    logic        eng_done;
    logic [7:0]  eng_data;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    flash_read_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_data(dma_data), .dma_ack(dma_ack),
        .eng_start(eng_start), .eng_addr(eng_addr), .eng_done(eng_done), .eng_data(eng_data),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " eng_start"}, 32'(eng_start), 32'h0);
        chk({tag, " eng_addr"}, 32'(eng_addr), 32'h0);
        chk({tag, " cpu_ready"}, 32'(cpu_ready), 32'h0);
        chk({tag, " cpu_data"}, 32'(cpu_data), 32'h0);
        chk({tag, " dma_ack"}, 32'(dma_ack), 32'h0);
        chk({tag, " dma_data"}, 32'(dma_data), 32'h0);
        chk({tag, " timeout_err"}, 32'(timeout_err), 32'h0);
    endtask

    // Advance into the ISSUE cycle following a grant and check the engine request.
    task automatic issue(input string tag, input logic [23:0] a);
        step();
        chk({tag, " eng_start"}, 32'(eng_start), 32'h1);
        chk({tag, " eng_addr"}, 32'(eng_addr), 32'(a));
    endtask

    // First WAIT cycle returns data; ends in the cycle the completion is visible.
    task automatic complete(input string tag, input logic [7:0] d);
        step();
        chk({tag, " start pulse width"}, 32'(eng_start), 32'h0);
        eng_done = 1'b1;
        eng_data = d;
        step();
        eng_done = 1'b0;
        chk({tag, " no early ready"}, 32'(cpu_ready | dma_ack), 32'h0);
        step();
    endtask

    initial begin
        reset = 1'b0; cpu_req = 1'b0; cpu_addr = 16'h0000;
        dma_req = 1'b0; dma_addr = 24'h0; eng_done = 1'b0; eng_data = 8'h00;
        step(); step();
        chk_reset_vals("reset");
        reset = 1'b1;

        // Tie straight after reset: CPU first, then DMA
        cpu_req = 1'b1; cpu_addr = 16'hF123; dma_req = 1'b1; dma_addr = 24'h010000;
        issue("tie1 cpu", 24'h000123);
        complete("tie1 cpu", 8'h11);
        chk("tie1 cpu_ready", 32'(cpu_ready), 32'h1);
        chk("tie1 cpu_data", 32'(cpu_data), 32'h11);
        cpu_req = 1'b0;
        issue("tie1 dma", 24'h010000);
        chk("tie1 cpu_ready drop", 32'(cpu_ready), 32'h0);
        complete("tie1 dma", 8'h22);
        chk("tie1 dma_ack", 32'(dma_ack), 32'h1);
        chk("tie1 dma_data", 32'(dma_data), 32'h22);
        dma_addr = 24'h010001;

        // dma_req held through ack is a fresh request
        step();
        chk("dma ack pulse", 32'(dma_ack), 32'h0);
        issue("dma repeat", 24'h010001);
        dma_req = 1'b0;
        complete("dma repeat", 8'h23);
        chk("dma repeat dma_data", 32'(dma_data), 32'h23);

        // CPU miss F123 -> 5A
        cpu_req = 1'b1; cpu_addr = 16'hF123;
        issue("cpu miss", 24'h000123);
        complete("cpu miss", 8'h5A);
        chk("cpu miss cpu_ready", 32'(cpu_ready), 32'h1);
        chk("cpu miss cpu_data", 32'(cpu_data), 32'h5A);
        cpu_req = 1'b0;
        step();
        chk("cpu_ready clear", 32'(cpu_ready), 32'h0);

        // Repeat read hits the cache next cycle
        cpu_req = 1'b1;
        step();
        chk("hit cpu_ready", 32'(cpu_ready), 32'h1);
        chk("hit cpu_data", 32'(cpu_data), 32'h5A);
        chk("hit no eng_start", 32'(eng_start), 32'h0);
        cpu_req = 1'b0;
        step();
        chk("hit eng_start idle", 32'(eng_start), 32'h0);

        // Tie after a CPU grant: DMA first
        cpu_req = 1'b1; cpu_addr = 16'hF456; dma_req = 1'b1; dma_addr = 24'h020000;
        issue("tie2 dma", 24'h020000);
        complete("tie2 dma", 8'h33);
        chk("tie2 dma_data", 32'(dma_data), 32'h33);
        chk("tie2 cpu waits", 32'(cpu_ready), 32'h0);
        dma_req = 1'b0;
        issue("tie2 cpu", 24'h000456);
        complete("tie2 cpu", 8'h44);
        chk("tie2 cpu_data", 32'(cpu_data), 32'h44);
        cpu_req = 1'b0;
        step();

        // CPU hit with DMA pending: hit served, DMA granted the next cycle
        cpu_req = 1'b1; cpu_addr = 16'hF456; dma_req = 1'b1; dma_addr = 24'h000123;
        step();
        chk("hit+dma cpu_ready", 32'(cpu_ready), 32'h1);
        chk("hit+dma cpu_data", 32'(cpu_data), 32'h44);
        chk("hit+dma no start", 32'(eng_start), 32'h0);
        cpu_req = 1'b0;
        issue("hit+dma dma", 24'h000123);
        complete("hit+dma dma", 8'h3C);
        chk("hit+dma dma_ack", 32'(dma_ack), 32'h1);
        chk("hit+dma dma_data", 32'(dma_data), 32'h3C);
        dma_req = 1'b0;

        // DMA-loaded entry serves a CPU read
        cpu_req = 1'b1; cpu_addr = 16'hF123;
        step();
        chk("dma fill hit ready", 32'(cpu_ready), 32'h1);
        chk("dma fill hit data", 32'(cpu_data), 32'h3C);
        cpu_req = 1'b0;
        step();

        // Timeout after 4 WAIT cycles
        cpu_req = 1'b1; cpu_addr = 16'hF200;
        issue("timeout", 24'h000200);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("timeout waiting", 32'(cpu_ready), 32'h0);
        end
        chk("timeout_err before abort", 32'(timeout_err), 32'h0);
        step();
        chk("timeout_err set", 32'(timeout_err), 32'h1);
        step();
        chk("timeout cpu_ready", 32'(cpu_ready), 32'h1);
        chk("timeout cpu_data", 32'(cpu_data), 32'hFF);
        cpu_req = 1'b0;
        step();

        // Cache invalidated by the abort: F123 misses
        cpu_req = 1'b1; cpu_addr = 16'hF123;
        issue("after abort", 24'h000123);
        complete("after abort", 8'h5A);
        chk("after abort cpu_data", 32'(cpu_data), 32'h5A);
        chk("timeout_err sticky", 32'(timeout_err), 32'h1);
        cpu_req = 1'b0;
        step();

        // Reset during WAIT, late eng_done after release
        cpu_req = 1'b1; cpu_addr = 16'hF300;
        issue("pre reset", 24'h000300);
        step();
        reset = 1'b0; cpu_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        eng_done = 1'b1; eng_data = 8'h99;
        step();
        eng_done = 1'b0;
        chk_reset_vals("mid reset");
        step(); step();
        chk("late done no ready", 32'(cpu_ready), 32'h0);
        chk("late done no ack", 32'(dma_ack), 32'h0);
        chk("late done no start", 32'(eng_start), 32'h0);
        chk("late done cpu_data", 32'(cpu_data), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
